// File: rtl/pipeline_3_result_sink.sv
// pipeline_3_result_sink: FWFT result FIFO with valid/ready output and saturating sum, sample count and sticky drop statistics.
module pipeline_3_result_sink #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     f_in,
  input  logic             f_valid,
  input  logic             clr,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [ACC_W-1:0] acc_sum,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [N-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [N-1:0]     last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [ACC_W:0]   acc_wide;
  logic [CNT_W-1:0] smp_q, smp_d, smp_base;
  logic             drop_q, drop_d;
  logic             pop, push, drop_ev;
  assign empty      = cnt_q == '0;
  assign full       = cnt_q == FULL_CNT;
  assign out_valid  = !empty;
  // Once drained, the output keeps showing the last value handed on.
  assign out_data   = empty ? last_q : mem_q[rd_ptr_q];
  assign acc_sum    = acc_q;
  assign sample_cnt = smp_q;
  assign drop       = drop_q;
  always_comb begin
    pop      = out_valid && out_ready;
    push     = f_valid && (!full || pop);
    drop_ev  = f_valid && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    // clr acts first, so a push in the same cycle starts the statistics afresh.
    acc_base = clr ? '0 : acc_q;
    acc_wide = {1'b0, acc_base} + (ACC_W+1)'(f_in);
    acc_d    = !push ? acc_base : acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
    smp_base = clr ? '0 : smp_q;
    smp_d    = push ? smp_base + CNT_W'(1) : smp_base;
    drop_d   = (clr ? 1'b0 : drop_q) || drop_ev;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= f_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: tb/tb_pipeline_3_result_sink.sv
// tb_pipeline_3_result_sink: directed vector table for the default instance plus a saturation/wrap sequence on a narrow instance.
module tb_pipeline_3_result_sink;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, f_valid, clr, out_ready, out_valid, full, empty, drop;
  logic [9:0] f_in, out_data;
  logic [15:0] acc_sum;
  logic [7:0] sample_cnt;
  logic s_rst_n, s_fv, s_clr, s_rdy, s_ov, s_full, s_empty, s_drop;
  logic [9:0] s_f, s_od, s_acc;
  logic [1:0] s_cnt;
  int total = 0;
  int bad = 0;
  pipeline_3_result_sink dut (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .f_valid(f_valid), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .acc_sum(acc_sum), .sample_cnt(sample_cnt), .drop(drop)
  );
  pipeline_3_result_sink #(.N(10), .DEPTH(4), .ACC_W(10), .CNT_W(2)) sat (
    .clk(clk), .rst_n(s_rst_n), .f_in(s_f), .f_valid(s_fv), .clr(s_clr),
    .out_data(s_od), .out_valid(s_ov), .out_ready(s_rdy),
    .full(s_full), .empty(s_empty), .acc_sum(s_acc), .sample_cnt(s_cnt), .drop(s_drop)
  );
  typedef struct {
    bit rst_n; bit fv; int f; bit rdy; bit clr;
    bit ov; int od; bit full; bit empty; int acc; int cnt; bit drop;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask
  task automatic sat_push(input int val);
    s_fv = 1'b1;
    s_f = 10'(val);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_in = '0; clr = 1'b0; out_ready = 1'b0;
    s_rst_n = 1'b0; s_fv = 1'b0; s_f = '0; s_clr = 1'b0; s_rdy = 1'b1;
    v.push_back('{0,1,77,0,0,  0,0,0,1,0,0,0});
    v.push_back('{0,1,77,0,0,  0,0,0,1,0,0,0});
    v.push_back('{1,1,69,1,0,  1,69,0,0,69,1,0});
    v.push_back('{1,1,36,1,0,  1,36,0,0,105,2,0});
    v.push_back('{1,1,132,1,0, 1,132,0,0,237,3,0});
    v.push_back('{1,0,0,1,0,   0,132,0,1,237,3,0});
    v.push_back('{1,0,0,0,1,   0,132,0,1,0,0,0});
    v.push_back('{1,1,1,0,0,   1,1,0,0,1,1,0});
    v.push_back('{1,1,2,0,0,   1,1,0,0,3,2,0});
    v.push_back('{1,1,3,0,0,   1,1,0,0,6,3,0});
    v.push_back('{1,1,4,0,0,   1,1,1,0,10,4,0});
    v.push_back('{1,1,5,0,0,   1,1,1,0,10,4,1});
    v.push_back('{1,0,0,0,1,   1,1,1,0,0,0,0});
    v.push_back('{1,1,9,1,0,   1,2,1,0,9,1,0});
    v.push_back('{1,0,0,1,0,   1,3,0,0,9,1,0});
    v.push_back('{1,0,0,1,0,   1,4,0,0,9,1,0});
    v.push_back('{1,0,0,1,0,   1,9,0,0,9,1,0});
    v.push_back('{1,0,0,1,0,   0,9,0,1,9,1,0});
    v.push_back('{1,1,500,0,1, 1,500,0,0,500,1,0});
    v.push_back('{1,1,10,0,0,  1,500,0,0,510,2,0});
    v.push_back('{1,1,20,0,0,  1,500,0,0,530,3,0});
    v.push_back('{1,1,30,0,0,  1,500,1,0,560,4,0});
    v.push_back('{1,1,40,0,0,  1,500,1,0,560,4,1});
    v.push_back('{1,0,0,1,0,   1,10,0,0,560,4,1});
    v.push_back('{1,1,7,0,1,   1,10,1,0,7,1,0});
    v.push_back('{0,1,99,1,0,  0,0,0,1,0,0,0});
    v.push_back('{1,1,11,0,0,  1,11,0,0,11,1,0});
    foreach (v[i]) begin
      rst_n = v[i].rst_n; f_valid = v[i].fv; f_in = 10'(v[i].f);
      out_ready = v[i].rdy; clr = v[i].clr;
      @(posedge clk);
      #1;
      chk("out_valid", i, int'(out_valid), int'(v[i].ov));
      chk("out_data", i, int'(out_data), v[i].od);
      chk("full", i, int'(full), int'(v[i].full));
      chk("empty", i, int'(empty), int'(v[i].empty));
      chk("acc_sum", i, int'(acc_sum), v[i].acc);
      chk("sample_cnt", i, int'(sample_cnt), v[i].cnt);
      chk("drop", i, int'(drop), int'(v[i].drop));
    end
    f_valid = 1'b0;
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    sat_push(1023);
    chk("sat_acc", 1, int'(s_acc), 1023);
    chk("sat_cnt", 1, int'(s_cnt), 1);
    sat_push(5);
    chk("sat_acc", 2, int'(s_acc), 1023);
    chk("sat_od", 2, int'(s_od), 5);
    sat_push(1);
    chk("sat_cnt", 3, int'(s_cnt), 3);
    sat_push(1);
    chk("sat_cnt", 4, int'(s_cnt), 0);
    sat_push(1);
    chk("sat_cnt", 5, int'(s_cnt), 1);
    chk("sat_acc", 5, int'(s_acc), 1023);
    chk("sat_drop", 5, int'(s_drop), 0);
    s_fv = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_empty", 6, int'(s_empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
